// File: rtl/cv32e40x_pkg.sv
// Shared RV32A definitions: AMO funct5 encodings and the atomic sequencer state type.
package cv32e40x_pkg;

    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    // SC.W result written to rd when the store is not performed
    localparam logic [31:0] AMO_SC_FAIL = 32'd1;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StResp
    } amo_seq_state_e;

    function automatic logic is_amo_rmw(input logic [4:0] funct5);
        case (funct5)
            AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND, AMO_OR,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cv32e40x_amo_alu.sv
// Combinational read-modify-write datapath for AMO*.W: new word from old memory word and rs2.
module cv32e40x_amo_alu
    import cv32e40x_pkg::*;
(
    input  logic [4:0]  funct5,
    input  logic [31:0] mem_word,
    input  logic [31:0] rs2,
    output logic [31:0] result
);

    logic signed_lt;
    logic unsigned_lt;

    assign signed_lt   = $signed(mem_word) < $signed(rs2);
    assign unsigned_lt = mem_word < rs2;

    always_comb begin
        result = rs2;
        case (funct5)
            AMO_SWAP: result = rs2;
            AMO_ADD:  result = mem_word + rs2;
            AMO_XOR:  result = mem_word ^ rs2;
            AMO_AND:  result = mem_word & rs2;
            AMO_OR:   result = mem_word | rs2;
            AMO_MIN:  result = signed_lt ? mem_word : rs2;
            AMO_MAX:  result = signed_lt ? rs2 : mem_word;
            AMO_MINU: result = unsigned_lt ? mem_word : rs2;
            AMO_MAXU: result = unsigned_lt ? rs2 : mem_word;
            default:  result = rs2;
        endcase
    end

endmodule

// File: rtl/cv32e40x_amo_seq.sv
// RV32A word-atomic sequencer between LSU and data-side OBI; owns the LR/SC reservation.
// Define CV32E40X_LRSC_RESV_EN to build the reservation register; otherwise every SC fails.
module cv32e40x_amo_seq
    import cv32e40x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  req_atop_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    input  logic        clear_resv_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    amo_seq_state_e state_q, state_d;
    logic [29:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [4:0]     funct5_q, funct5_d;
    logic           err_q, err_d;
    logic           resv_set, resv_clr;
    logic           sc_match, resv_hit;
    logic [31:0]    amo_result;

    cv32e40x_amo_alu u_amo_alu (
        .funct5   (funct5_q),
        .mem_word (bus_rdata_i),
        .rs2      (wdata_q),
        .result   (amo_result)
    );

`ifdef CV32E40X_LRSC_RESV_EN
    logic        resv_valid_q;
    logic [29:0] resv_addr_q;

    // clear wins over a same-cycle LR set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else if (clear_resv_i || resv_clr) begin
            resv_valid_q <= 1'b0;
        end else if (resv_set) begin
            resv_valid_q <= 1'b1;
            resv_addr_q  <= addr_q;
        end
    end

    assign sc_match = resv_valid_q && (resv_addr_q == req_addr_i[31:2]);
    assign resv_hit = resv_valid_q && (resv_addr_q == addr_q);

    logic unused_sig;
    assign unused_sig = ^req_addr_i[1:0];
`else
    assign sc_match = 1'b0;
    assign resv_hit = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{req_addr_i[1:0], clear_resv_i, resv_clr, resv_set};
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        funct5_d = funct5_q;
        err_d    = err_q;
        resv_set = 1'b0;
        resv_clr = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i[31:2];
                    wdata_d  = req_wdata_i;
                    funct5_d = req_atop_i[4:0];
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    if (!req_atop_i[5]) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (req_atop_i[4:0] == AMO_LR) begin
                        state_d = StRdReq;
                    end else if (req_atop_i[4:0] == AMO_SC) begin
                        resv_clr = 1'b1;
                        if (sc_match) begin
                            state_d = StWrReq;
                        end else begin
                            rdata_d = AMO_SC_FAIL;
                            state_d = StResp;
                        end
                    end else if (is_amo_rmw(req_atop_i[4:0])) begin
                        state_d = StRdReq;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StRdReq: begin
                if (bus_gnt_i) state_d = StRdWait;
            end
            StRdWait: begin
                if (bus_rvalid_i) begin
                    rdata_d = bus_rdata_i;
                    if (bus_err_i) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (funct5_q == AMO_LR) begin
                        resv_set = 1'b1;
                        state_d  = StResp;
                    end else begin
                        // rs2 is no longer needed, so the store data register holds the new word
                        wdata_d = amo_result;
                        state_d = StWrReq;
                    end
                end
            end
            StWrReq: begin
                if (bus_gnt_i) begin
                    state_d = StWrWait;
                    if (funct5_q != AMO_SC && resv_hit) resv_clr = 1'b1;
                end
            end
            StWrWait: begin
                if (bus_rvalid_i) begin
                    err_d   = bus_err_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct5_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct5_q <= funct5_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    assign bus_req_o   = (state_q == StRdReq) || (state_q == StWrReq);
    assign bus_we_o    = (state_q == StWrReq);
    assign bus_addr_o  = {addr_q, 2'b00};
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = 4'hF;

endmodule

// File: doc/cv32e40x_amo_seq.md
# cv32e40x_amo_seq

Sequencer for RV32A word atomics between the load-store unit and the data-side OBI bus. It accepts one decoded atomic request at a time (LR.W, SC.W, AMO*.W) and issues the required read and/or write bus transactions. For AMO*.W it computes the read-modify-write value and returns the old memory word. It also owns the single LR/SC reservation register.

## Interface
Parameters:
- none; data and address width fixed at 32.

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  1  atomic request valid
- req_ready_o  out  1  sequencer can accept (high only in IDLE)
- req_atop_i  in  6  [5]=atomic flag, [4:0]=funct5 (AMO_* encodings)
- req_addr_i  in  32  word address (bits [1:0] ignored)
- req_wdata_i  in  32  rs2 operand
- resp_valid_o  out  1  one-cycle result pulse
- resp_rdata_o  out  32  LR/AMO: old memory word; SC: 0 success, 1 failure
- resp_err_o  out  1  bus error or unsupported funct5
- clear_resv_i  in  1  drop reservation (trap, xRET, debug entry)
- bus_req_o  out  1  OBI request
- bus_gnt_i  in  1  OBI grant
- bus_addr_o  out  32  {addr[31:2],2'b00}
- bus_we_o  out  1  write enable
- bus_be_o  out  4  always 4'hF
- bus_wdata_o  out  32  store data
- bus_rvalid_i  in  1  OBI response valid
- bus_rdata_i  in  32  read data
- bus_err_i  in  1  response error, qualified by bus_rvalid_i

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch addr, wdata and atop, then branch:
  - LR → RD_REQ.
  - SC with reservation valid and matching addr[31:2] → WR_REQ with wdata = rs2.
  - SC without a valid matching reservation → RESP with rdata=1; no bus access.
  - AMO* → RD_REQ.
  - Unsupported funct5, or atop[5]=0 → RESP with err=1; no bus access.
- RD_REQ/WR_REQ: bus_req_o=1; addr, we and wdata stay stable until bus_gnt_i; on grant go to the matching *_WAIT.
- RD_WAIT: on bus_rvalid_i latch rdata.
  - err → RESP with err=1; no write is issued.
  - LR → set reservation {valid, addr[31:2]}, then RESP.
  - AMO → compute new value, then WR_REQ.
- AMO compute:
  - SWAP = rs2.
  - ADD = (mem+rs2) mod 2^32.
  - XOR/AND/OR are bitwise.
  - MIN/MAX use 32-bit signed compare; MINU/MAXU use unsigned compare.
- WR_WAIT: on bus_rvalid_i go to RESP; err propagates to resp_err_o.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. The consumer always accepts (no backpressure).
- Reservation is cleared by:
  - any SC (success or failure), at the SC accept;
  - an AMO write grant whose addr matches the reservation;
  - clear_resv_i, in any state.
- clear_resv_i has priority over a same-cycle LR set.
- Only one bus transaction is outstanding at any time.

## Timing
- Reset values:
  - state=IDLE, reservation invalid.
  - bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_be_o=4'hF.
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, req_ready_o=1.
- Reset is asynchronous: asserting it mid-transaction drops bus_req_o immediately, abandons any pending bus response and invalidates the reservation.
- Bus outputs are registered from state; a request in cycle N appears on the bus in N+1.
- Minimum latencies, with grant on the first request cycle and rvalid one cycle after grant:
  - AMO: accept N, rd req N+1, rvalid N+2, wr req N+3, rvalid N+4, resp N+5.
  - LR: resp N+3.
  - Failing SC: resp N+1.
- bus_rvalid_i outside a *_WAIT state is ignored.
- req_valid_i outside IDLE is ignored (ready=0).

## Configuration
- CV32E40X_LRSC_RESV_EN
  - Defined: reservation register and matching behave as described above.
  - Undefined: no reservation storage; LR is a plain read; every SC returns 1 with no bus access; clear_resv_i is unused.

## Structure
- Shared package cv32e40x_pkg holds:
  - amo_seq_state_e (6-state enum);
  - the existing AMO_* funct5 constants;
  - a new AMO_SC_FAIL = 32'd1 constant.
- Sub-module cv32e40x_amo_alu (combinational): inputs funct5, mem word and rs2; output new word. It is the only arithmetic in the block.

## Test plan
- AMOADD.W: mem[0x100]=0xFFFF_FFFF, rs2=2 → read then write of 0x0000_0001; resp_rdata_o=0xFFFF_FFFF; resp at N+5 with zero-wait bus.
- AMOMIN.W vs AMOMINU.W: mem=0x8000_0000, rs2=1 → MIN writes 0x8000_0000, MINU writes 0x0000_0001.
- LR.W 0x200 then SC.W 0x200 rs2=0x55 → write 0x55, resp 0; a second SC.W 0x200 → resp 1, no bus_req_o.
- LR.W 0x200, clear_resv_i pulse, SC.W 0x200 → resp 1, no write; also LR.W then AMOSWAP.W 0x200 then SC → fail.
- AMOOR.W with bus_err_i on read → resp_err_o=1, no write request, back to IDLE.
- Reset asserted in WR_REQ with bus_gnt_i held 0 → bus_req_o=0 in same cycle, req_ready_o=1, next SC fails.
